fpu_mul_arbiter: RTL



---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fpu_mul_arbiter_mult.sv | 83 ++++++++
 rtl/fpu_mul_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU definitions: bfloat16 type, multiplier-arbiter FSM
//               state encoding and the canonical quiet NaN constant.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    typedef logic [15:0] bf16_t;

    // Explicit 2-bit encodings, kept as constants for legacy users that
    // compare raw state bits.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        EXEC = ST_EXEC,
        RESP = ST_RESP
    } mul_arb_state_e;

    localparam bf16_t BF16_QNAN = 16'h7FC0;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_mul_arbiter_mult.sv
`default_nettype none
// ============================================================================
// Module      : Mult
// Description : Combinational bfloat16 multiplier, round-to-nearest-even.
//               Subnormal inputs and results flush to signed zero; any NaN
//               operand or inf*0 yields the canonical quiet NaN.
// Ports       : i_a, i_b  - bf16 operands
//               i_inst    - 0: multiply, 1: negated multiply
//               o_result  - bf16 product
// Revision    : 1.0 - initial release
// ============================================================================
module Mult
    import fpu_pkg::*;
(
    input  bf16_t i_a,
    input  bf16_t i_b,
    input  logic  i_inst,
    output bf16_t o_result
);

    logic [7:0]        w_ea, w_eb;
    logic [6:0]        w_ma, w_mb;
    logic              w_sign;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [15:0]       w_prod;
    logic signed [9:0] w_exp;
    logic [6:0]        w_mant;
    logic              w_guard, w_sticky, w_round;
    logic [7:0]        w_mant_r;

    assign w_ea = i_a[14:7];
    assign w_eb = i_b[14:7];
    assign w_ma = i_a[6:0];
    assign w_mb = i_b[6:0];

    always_comb begin
        w_sign   = i_a[15] ^ i_b[15] ^ i_inst;
        w_a_nan  = (&w_ea) && (|w_ma);
        w_b_nan  = (&w_eb) && (|w_mb);
        w_a_inf  = (&w_ea) && !(|w_ma);
        w_b_inf  = (&w_eb) && !(|w_mb);
        w_a_zero = !(|w_ea);
        w_b_zero = !(|w_eb);

        w_prod = {8'h00, 1'b1, w_ma} * {8'h00, 1'b1, w_mb};
        w_exp  = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

        // Product of two 1.x significands lies in [1,4); normalise by one bit
        // when it reaches 2.
        if (w_prod[15]) begin
            w_mant   = w_prod[14:8];
            w_guard  = w_prod[7];
            w_sticky = |w_prod[6:0];
            w_exp    = w_exp + 10'sd1;
        end else begin
            w_mant   = w_prod[13:7];
            w_guard  = w_prod[6];
            w_sticky = |w_prod[5:0];
        end

        w_round  = w_guard && (w_sticky || w_mant[0]);
        w_mant_r = {1'b0, w_mant} + {7'd0, w_round};
        if (w_mant_r[7]) begin
            w_exp = w_exp + 10'sd1;
        end

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            o_result = BF16_QNAN;
        end else if (w_a_inf || w_b_inf) begin
            o_result = {w_sign, 8'hFF, 7'h00};
        end else if (w_a_zero || w_b_zero) begin
            o_result = {w_sign, 15'h0000};
        end else if (w_exp >= 10'sd255) begin
            o_result = {w_sign, 8'hFF, 7'h00};
        end else if (w_exp <= 10'sd0) begin
            o_result = {w_sign, 15'h0000};
        end else begin
            o_result = {w_sign, w_exp[7:0], w_mant_r[6:0]};
        end
    end

endmodule : Mult
`default_nettype wire

// File: rtl/fpu_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mul_arbiter
// Description : Two-requester round-robin arbiter/sequencer for the shared
//               bf16 multiplier. IDLE -> EXEC -> RESP, one op per 3 cycles.
// Ports       : clk_i, rst_i            - clock, sync active-high reset
//               req_valid_i/req_ready_o - per-requester request handshake
//               req_a_i/req_b_i         - operands, requester i at [16*i +: 16]
//               rsp_valid_o/rsp_ready_i - per-requester response handshake
//               rsp_result_o            - bf16 product
//               busy_o                  - high outside IDLE
//               perf_mul_cnt_o, perf_stall_cnt_o - saturating counters,
//                 present only when FPU_MUL_ARB_PERF_EN is defined
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_mul_arbiter
    import fpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    output logic [1:0]       rsp_valid_o,
    input  logic [1:0]       rsp_ready_i,
    output logic [15:0]      rsp_result_o,
    output logic             busy_o
`ifdef FPU_MUL_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_mul_cnt_o,
    output logic [CNT_W-1:0] perf_stall_cnt_o
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    mul_arb_state_e state_q;
    bf16_t          op_a_q, op_b_q, res_q;
    logic           owner_q;
    logic           last_q;

    logic           w_grant;
    logic           w_req_hs;
    logic           w_rsp_hs;
    bf16_t          w_product;

    // Grant: lone requester wins; under contention the one not served last.
    always_comb begin
        w_grant = 1'b0;
        case (req_valid_i)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~last_q;
            default: w_grant = 1'b0;
        endcase

        req_ready_o = 2'b00;
        if ((state_q == IDLE) && !rst_i && (|req_valid_i)) begin
            req_ready_o = w_grant ? 2'b10 : 2'b01;
        end
    end

    assign w_req_hs     = |req_ready_o;
    assign w_rsp_hs     = (state_q == RESP) && rsp_ready_i[owner_q];
    assign rsp_valid_o  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result_o = res_q;
    assign busy_o       = (state_q != IDLE);

    Mult u_mult (
        .i_a      (op_a_q),
        .i_b      (op_b_q),
        .i_inst   (1'b0),
        .o_result (w_product)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_req_hs) begin
                        op_a_q  <= w_grant ? req_a_i[31:16] : req_a_i[15:0];
                        op_b_q  <= w_grant ? req_b_i[31:16] : req_b_i[15:0];
                        owner_q <= w_grant;
                        last_q  <= w_grant;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= w_product;
                    state_q <= RESP;
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FPU_MUL_ARB_PERF_EN
    logic w_stall;
    assign w_stall = |(req_valid_i & ~req_ready_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_mul_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (w_rsp_hs && !(&perf_mul_cnt_o)) begin
                perf_mul_cnt_o <= perf_mul_cnt_o + 1'b1;
            end
            if (w_stall && !(&perf_stall_cnt_o)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule : fpu_mul_arbiter
`default_nettype wire
